// File: rtl/sa_matmul_gen2_pkg.sv
// Shared definitions for the gen2 systolic matrix multiplier: FSM state
// encodings, a constant clog2 helper and the default accumulator width macro.
// Optional feature macro used by the design: SA_ACC_SATURATE_EN.

`ifndef SA_DEFAULT_ACC_WIDTH
`define SA_DEFAULT_ACC_WIDTH(dw, sz) (2*(dw)+sa_matmul_gen2_pkg::sa_clog2(sz))
`endif

package sa_matmul_gen2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sa_state_e;

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int sa_clog2(input int value);
    int r;
    r = 1;
    while ((32'd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell. Operands pass through to the right (a) and
// downward (b) with one register each; the product is accumulated locally.
// With SA_ACC_SATURATE_EN defined the accumulator clamps to the ACC_WIDTH
// range and stays clamped until the next clear; otherwise it wraps.

module sa_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int   PW        = 2 * DATA_WIDTH;
  localparam logic IS_SIGNED = (SIGNED != 0);

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        b_ext;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] acc_next;

  // Full-width product; extending the operands first makes the low PW bits
  // correct for both unsigned and two's complement operands.
  always_comb begin
    if (IS_SIGNED) begin
      a_ext = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
      b_ext = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
    end else begin
      a_ext = {{DATA_WIDTH{1'b0}}, a_in};
      b_ext = {{DATA_WIDTH{1'b0}}, b_in};
    end
    prod = a_ext * b_ext;
  end

`ifdef SA_ACC_SATURATE_EN
  // Sum is formed one bit wider than either operand so it never overflows,
  // then clamped back into the accumulator range.
  localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = IS_SIGNED ?
      {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = IS_SIGNED ?
      {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  logic [SW-1:0]        acc_w;
  logic [SW-1:0]        prod_w;
  logic [SW-1:0]        sum_w;
  logic [SW-ACC_WIDTH:0] sum_top;
  logic                 sat;
  logic                 sat_next;

  // Saturating accumulate with a sticky flag so a clamped value never recovers.
  always_comb begin
    acc_w   = {{(SW-ACC_WIDTH){IS_SIGNED & acc[ACC_WIDTH-1]}}, acc};
    prod_w  = {{(SW-PW){IS_SIGNED & prod[PW-1]}}, prod};
    sum_w   = acc_w + prod_w;
    sum_top = sum_w[SW-1:ACC_WIDTH-1];
    if (sat) begin
      acc_next = acc;
      sat_next = 1'b1;
    end else if (IS_SIGNED) begin
      if ((&sum_top) | ~(|sum_top)) begin
        acc_next = sum_w[ACC_WIDTH-1:0];
        sat_next = 1'b0;
      end else begin
        acc_next = sum_w[SW-1] ? ACC_MIN : ACC_MAX;
        sat_next = 1'b1;
      end
    end else begin
      if (|sum_top[SW-ACC_WIDTH:1]) begin
        acc_next = ACC_MAX;
        sat_next = 1'b1;
      end else begin
        acc_next = sum_w[ACC_WIDTH-1:0];
        sat_next = 1'b0;
      end
    end
  end
`else
  logic [ACC_WIDTH-1:0] prod_acc;

  // Fit the product to the accumulator: extend per signedness or keep the LSBs.
  if (ACC_WIDTH > PW) begin : g_prod_ext
    always_comb prod_acc = {{(ACC_WIDTH-PW){IS_SIGNED & prod[PW-1]}}, prod};
  end else if (ACC_WIDTH == PW) begin : g_prod_same
    always_comb prod_acc = prod;
  end else begin : g_prod_trunc
    always_comb prod_acc = prod[ACC_WIDTH-1:0];
  end

  // Wrapping accumulate modulo 2^ACC_WIDTH.
  always_comb acc_next = acc + prod_acc;
`endif

  // Operand pipes and accumulator; clr wipes the cell at the start of a job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
`ifdef SA_ACC_SATURATE_EN
      sat   <= 1'b0;
`endif
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
`ifdef SA_ACC_SATURATE_EN
      sat   <= 1'b0;
`endif
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_next;
`ifdef SA_ACC_SATURATE_EN
      sat   <= sat_next;
`endif
    end
  end

endmodule

// File: rtl/sa_matmul_gen2.sv
// Output-stationary systolic matrix multiplier C = A x B with a start/busy/done
// handshake. Operands are latched on start, skewed by the edge feeders and
// streamed through a SIZE x SIZE grid of sa_pe cells; the accumulators are
// copied to C once per job. Optional feature macro: SA_ACC_SATURATE_EN.

module sa_matmul_gen2
  import sa_matmul_gen2_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = `SA_DEFAULT_ACC_WIDTH(DATA_WIDTH, SIZE),
  parameter int SIGNED     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] A,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] B,
  output logic                            busy,
  output logic                            done,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0]  C
);

  localparam int OPW    = SIZE * SIZE * DATA_WIDTH;
  localparam int STEP_W = sa_clog2(3 * SIZE);
  // Feeders emit SIZE-1 skew steps on each side of the SIZE data steps plus one
  // trailing zero step, so the final step index is 3*SIZE-2.
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3 * SIZE - 2);

  sa_state_e                  state;
  logic [STEP_W-1:0]          step;
  logic [OPW-1:0]             a_reg;
  logic [OPW-1:0]             b_reg;
  logic                       pe_clr;
  logic [DATA_WIDTH-1:0]      row_feed [SIZE];
  logic [DATA_WIDTH-1:0]      col_feed [SIZE];
  logic [DATA_WIDTH-1:0]      a_link   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0]      b_link   [SIZE][SIZE];
  logic [ACC_WIDTH-1:0]       acc_grid [SIZE][SIZE];
  logic [SIZE*SIZE*ACC_WIDTH-1:0] acc_flat;

  // The whole grid is cleared during the single LOAD cycle.
  always_comb pe_clr = (state == ST_LOAD);

  // Skew feeders: row i sends A[i][t-i], column i sends B[t-i][i] while in range.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      row_feed[i] = '0;
      col_feed[i] = '0;
      if ((state == ST_RUN) && (int'(step) >= i) && ((int'(step) - i) < SIZE)) begin
        row_feed[i] = a_reg[(i*SIZE + int'(step) - i)*DATA_WIDTH +: DATA_WIDTH];
        col_feed[i] = b_reg[((int'(step) - i)*SIZE + i)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        row_feed[i] = '0;
        col_feed[i] = '0;
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_src;
      logic [DATA_WIDTH-1:0] b_src;

      if (j == 0) begin : g_a_edge
        assign a_src = row_feed[i];
      end else begin : g_a_link
        assign a_src = a_link[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_src = col_feed[j];
      end else begin : g_b_link
        assign b_src = b_link[i-1][j];
      end

      sa_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (pe_clr),
        .a_in  (a_src),
        .b_in  (b_src),
        .a_out (a_link[i][j]),
        .b_out (b_link[i][j]),
        .acc   (acc_grid[i][j])
      );

      assign acc_flat[(i*SIZE + j)*ACC_WIDTH +: ACC_WIDTH] = acc_grid[i][j];
    end
  end

  // Job sequencer: operand capture, step counting, handshake and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      step  <= '0;
      a_reg <= '0;
      b_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      C     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_LOAD: begin
          step  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (step == LAST_STEP) begin
            state <= ST_DRAIN;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        ST_DRAIN: begin
          C     <= acc_flat;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_matmul_gen2.sv
// Directed bench for sa_matmul_gen2: four parameterisations share one clock and
// reset (SIZE=2 unsigned, SIZE=4 unsigned, SIZE=2 signed, SIZE=2 with an 8-bit
// accumulator). Expected results are hand-computed constants.

module tb_sa_matmul_gen2;

  logic clk = 1'b0;
  logic rst;

  logic        s2_start, s2_busy, s2_done;
  logic [31:0] s2_a, s2_b;
  logic [67:0] s2_c;

  logic         s4_start, s4_busy, s4_done;
  logic [127:0] s4_a, s4_b;
  logic [287:0] s4_c;

  logic        sg_start, sg_busy, sg_done;
  logic [31:0] sg_a, sg_b;
  logic [67:0] sg_c;

  logic        a8_start, a8_busy, a8_done;
  logic [31:0] a8_a, a8_b;
  logic [31:0] a8_c;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [67:0] c;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sa_matmul_gen2 #(.SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(17), .SIGNED(0)) u_s2 (
    .clk(clk), .rst(rst), .start(s2_start), .A(s2_a), .B(s2_b),
    .busy(s2_busy), .done(s2_done), .C(s2_c));

  sa_matmul_gen2 #(.SIZE(4), .DATA_WIDTH(8), .ACC_WIDTH(18), .SIGNED(0)) u_s4 (
    .clk(clk), .rst(rst), .start(s4_start), .A(s4_a), .B(s4_b),
    .busy(s4_busy), .done(s4_done), .C(s4_c));

  sa_matmul_gen2 #(.SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(17), .SIGNED(1)) u_sg (
    .clk(clk), .rst(rst), .start(sg_start), .A(sg_a), .B(sg_b),
    .busy(sg_busy), .done(sg_done), .C(sg_c));

  sa_matmul_gen2 #(.SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(8), .SIGNED(0)) u_a8 (
    .clk(clk), .rst(rst), .start(a8_start), .A(a8_a), .B(a8_b),
    .busy(a8_busy), .done(a8_done), .C(a8_c));

  function automatic logic [31:0] pk2(input int e00, input int e01, input int e10, input int e11);
    return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  function automatic logic [67:0] pc17(input int e00, input int e01, input int e10, input int e11);
    return {17'(e11), 17'(e10), 17'(e01), 17'(e00)};
  endfunction

  function automatic logic [31:0] pc8(input int e00, input int e01, input int e10, input int e11);
    return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start on the selected instance and follow it to done with a bound.
  task automatic run_job(input int sel, input int exp_lat, input string name);
    int   lat;
    logic d;
    logic bz;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    d       = 1'b0;
    bz      = 1'b0;
    @(negedge clk);
    case (sel)
      0:       s2_start = 1'b1;
      1:       s4_start = 1'b1;
      2:       sg_start = 1'b1;
      default: a8_start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    s2_start = 1'b0; s4_start = 1'b0; sg_start = 1'b0; a8_start = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      case (sel)
        0:       begin d = s2_done; bz = s2_busy; end
        1:       begin d = s4_done; bz = s4_busy; end
        2:       begin d = sg_done; bz = sg_busy; end
        default: begin d = a8_done; bz = a8_busy; end
      endcase
      if (d) begin
        lat = n;
        if (bz) busy_ok = 1'b0;
      end else if (!bz) begin
        busy_ok = 1'b0;
      end
    end
    check({name, " latency"}, 288'(lat), 288'(exp_lat));
    check({name, " busy"}, 288'(busy_ok), 288'(1));
    @(posedge clk);
    #1;
    case (sel)
      0:       d = s2_done;
      1:       d = s4_done;
      2:       d = sg_done;
      default: d = a8_done;
    endcase
    check({name, " done_pulse"}, 288'(d), 288'(0));
  endtask

  initial begin
    int          dones;
    int          lat;
    logic        hold_ok;
    logic [67:0] prev_c;
    logic [287:0] exp4;

    rst = 1'b1;
    s2_start = 1'b0; s4_start = 1'b0; sg_start = 1'b0; a8_start = 1'b0;
    s2_a = '0; s2_b = '0; s4_a = '0; s4_b = '0;
    sg_a = '0; sg_b = '0; a8_a = '0; a8_b = '0;

    vecs[0] = '{"sq",     pk2(1, 2, 3, 4),         pk2(1, 2, 3, 4),         pc17(7, 10, 15, 22)};
    vecs[1] = '{"ident",  pk2(1, 0, 0, 1),         pk2(5, 6, 7, 8),         pc17(5, 6, 7, 8)};
    vecs[2] = '{"diag",   pk2(2, 0, 0, 3),         pk2(1, 1, 1, 1),         pc17(2, 2, 3, 3)};
    vecs[3] = '{"max",    pk2(255, 255, 255, 255), pk2(255, 255, 255, 255), pc17(130050, 130050, 130050, 130050)};
    vecs[4] = '{"zero",   pk2(0, 0, 0, 0),         pk2(9, 8, 7, 6),         pc17(0, 0, 0, 0)};
    vecs[5] = '{"swap",   pk2(0, 1, 1, 0),         pk2(1, 2, 3, 4),         pc17(3, 4, 1, 2)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst s2_busy", 288'(s2_busy), 288'(0));
    check("rst s2_done", 288'(s2_done), 288'(0));
    check("rst s2_c", 288'(s2_c), 288'(0));
    check("rst s4_c", 288'(s4_c), 288'(0));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven SIZE=2 unsigned jobs
    for (int v = 0; v < 6; v++) begin
      s2_a = vecs[v].a;
      s2_b = vecs[v].b;
      run_job(0, 7, vecs[v].name);
      check({vecs[v].name, " c"}, 288'(s2_c), 288'(vecs[v].c));
    end

    // SIZE=4: identity x B returns B, then all-ones x B gives column sums
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s4_a[(r*4+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
        s4_b[(r*4+c)*8 +: 8] = 8'(r*4 + c + 1);
        exp4[(r*4+c)*18 +: 18] = 18'(r*4 + c + 1);
      end
    end
    run_job(1, 13, "s4 ident");
    check("s4 ident c", s4_c, exp4);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s4_a[(r*4+c)*8 +: 8] = 8'd1;
        exp4[(r*4+c)*18 +: 18] = 18'(28 + 4*c);
      end
    end
    run_job(1, 13, "s4 ones");
    check("s4 ones c", s4_c, exp4);

    // Signed mode
    sg_a = pk2(-1, 2, 3, -4);
    sg_b = pk2(5, 6, 7, 8);
    run_job(2, 7, "sg mix");
    check("sg mix c", 288'(sg_c), 288'(pc17(9, 10, -13, -14)));
    sg_a = pk2(-128, -128, -128, -128);
    sg_b = pk2(127, 127, 127, 127);
    run_job(2, 7, "sg neg");
    check("sg neg c", 288'(sg_c), 288'(pc17(-32512, -32512, -32512, -32512)));

    // Narrow accumulator: saturate or wrap depending on the build
    a8_a = pk2(1, 2, 3, 4);
    a8_b = pk2(1, 2, 3, 4);
    run_job(3, 7, "a8 small");
    check("a8 small c", 288'(a8_c), 288'(pc8(7, 10, 15, 22)));
    a8_a = pk2(255, 255, 255, 255);
    a8_b = pk2(255, 255, 255, 255);
    run_job(3, 7, "a8 ovf");
`ifdef SA_ACC_SATURATE_EN
    check("a8 ovf c", 288'(a8_c), 288'(pc8(255, 255, 255, 255)));
`else
    check("a8 ovf c", 288'(a8_c), 288'(pc8(2, 2, 2, 2)));
`endif

    // Start while busy and during DONE is ignored; operands are latched once
    prev_c = vecs[5].c;
    s2_a = vecs[0].a;
    s2_b = vecs[0].b;
    @(negedge clk);
    s2_start = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    s2_a = pk2(9, 9, 9, 9);
    s2_b = pk2(9, 9, 9, 9);
    dones = 0;
    lat = 0;
    hold_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      s2_start = 1'b0;
      if (s2_done) begin
        dones++;
        if (lat == 0) lat = n;
      end
      if (n < 7 && s2_c !== prev_c) hold_ok = 1'b0;
      if (n == 2 || n == 4 || n == 7) s2_start = 1'b1;
    end
    check("ignore dones", 288'(dones), 288'(1));
    check("ignore latency", 288'(lat), 288'(7));
    check("ignore c_hold", 288'(hold_ok), 288'(1));
    check("ignore c", 288'(s2_c), 288'(vecs[0].c));
    s2_a = vecs[1].a;
    s2_b = vecs[1].b;
    run_job(0, 7, "second");
    check("second c", 288'(s2_c), 288'(vecs[1].c));

    // Reset in the middle of a run aborts the job at once
    s2_a = vecs[0].a;
    s2_b = vecs[0].b;
    @(negedge clk);
    s2_start = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort busy", 288'(s2_busy), 288'(0));
    check("abort done", 288'(s2_done), 288'(0));
    check("abort c", 288'(s2_c), 288'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (s2_done) dones++;
    end
    check("abort no_done", 288'(dones), 288'(0));
    check("abort c_after", 288'(s2_c), 288'(0));
    s2_a = vecs[3].a;
    s2_b = vecs[3].b;
    run_job(0, 7, "post_abort");
    check("post_abort c", 288'(s2_c), 288'(vecs[3].c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
